// File: rtl/ram_cfg_pkg.sv
// Shared configuration for the partitioned, power-gated RAM: the partition
// gating states and the init-pattern selectors.
package ram_cfg_pkg;

    typedef enum logic [1:0] {
        PS_INIT,
        PS_ON,
        PS_DRAIN,
        PS_OFF
    } part_state_t;

    localparam int unsigned RAM_RESET_ZERO = 0;
    localparam int unsigned RAM_RESET_SEQ  = 1;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ram_partition_ctrl.sv
// Gating controller for one partition: INIT/ON/DRAIN/OFF FSM, a shared
// row/drain counter and the row-initialisation write generator.
module ram_partition_ctrl
    import ram_cfg_pkg::*;
#(
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned NUM_PARTS  = 4,
    parameter int unsigned PART_IDX   = 0,
    parameter int unsigned RESET_VAL  = RAM_RESET_ZERO,
    parameter int unsigned SEQ_START  = 0,
    parameter int unsigned GATE_DELAY = 4,
    localparam int unsigned ROW_W     = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             gated_i,
    output logic             on_o,
    output logic             init_we_o,
    output logic [ROW_W-1:0] init_row_o,
    output logic [WIDTH-1:0] init_data_o
);

    localparam int unsigned ROWS  = DEPTH / NUM_PARTS;
    localparam int unsigned CNT_W = $clog2(max_u(ROWS, GATE_DELAY) + 1);

    part_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= PS_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // One counter serves both roles: row index in INIT, remaining delay in DRAIN.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        init_we_o = 1'b0;
        case (state_q)
            PS_INIT: begin
                if (gated_i) begin
                    state_d = PS_OFF;
                end else begin
                    init_we_o = 1'b1;
                    if (cnt_q == CNT_W'(ROWS - 1)) begin
                        state_d = PS_ON;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            PS_ON: begin
                if (gated_i) begin
                    state_d = PS_DRAIN;
                    cnt_d   = CNT_W'(GATE_DELAY - 1);
                end
            end
            PS_DRAIN: begin
                if (!gated_i) begin
                    state_d = PS_ON;
                end else if (cnt_q == '0) begin
                    state_d = PS_OFF;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            PS_OFF: begin
                if (!gated_i) begin
                    state_d = PS_INIT;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = PS_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    assign on_o       = (state_q == PS_ON);
    assign init_row_o = ROW_W'(PART_IDX * ROWS) + ROW_W'(cnt_q);

    always_comb begin
        init_data_o = '0;
        if (RESET_VAL == RAM_RESET_SEQ) begin
            init_data_o = WIDTH'(SEQ_START) + WIDTH'(init_row_o);
        end
    end

endmodule

// File: rtl/ram_partitioned_gated_seq.sv
// Partitioned multiport RAM with one-hot word lines; each partition is
// power-gated by its own controller and re-initialised on every wake-up.
module ram_partitioned_gated_seq
    import ram_cfg_pkg::*;
#(
    parameter int unsigned DEPTH        = 64,
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned NUM_RD_PORTS = 4,
    parameter int unsigned NUM_WR_PORTS = 2,
    parameter int unsigned NUM_PARTS    = 4,
    parameter int unsigned RESET_VAL    = RAM_RESET_ZERO,
    parameter int unsigned SEQ_START    = 0,
    parameter int unsigned READ_LATENCY = 0,
    parameter int unsigned GATE_DELAY   = 4,
    localparam int unsigned NUM_PARTS_LOG = $clog2(NUM_PARTS)
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NUM_PARTS-1:0]                    partitionGated_i,
    output logic [NUM_PARTS-1:0]                    partReady_o,
    output logic                                    ramReady_o,
    input  logic [NUM_RD_PORTS*NUM_PARTS_LOG-1:0]   rdDataPartition_i,
    input  logic [NUM_RD_PORTS*DEPTH-1:0]           addr_i,
    output logic [NUM_RD_PORTS*WIDTH-1:0]           data_o,
    output logic [NUM_RD_PORTS-1:0]                 rdValid_o,
    input  logic [NUM_WR_PORTS*DEPTH-1:0]           addrWr_i,
    input  logic [NUM_WR_PORTS*WIDTH-1:0]           dataWr_i,
    input  logic [NUM_WR_PORTS-1:0]                 wrEn_i,
    output logic [NUM_WR_PORTS-1:0]                 wrDropped_o
);

    localparam int unsigned ROWS  = DEPTH / NUM_PARTS;
    localparam int unsigned ROW_W = $clog2(DEPTH);

    logic [NUM_PARTS-1:0] part_on;
    logic [NUM_PARTS-1:0] init_we;
    logic [ROW_W-1:0]     init_row  [NUM_PARTS];
    logic [WIDTH-1:0]     init_data [NUM_PARTS];

    logic [WIDTH-1:0]        mem_q [DEPTH];
    logic [WIDTH-1:0]        mem_d [DEPTH];
    logic [NUM_WR_PORTS-1:0] wr_commit;
    logic [NUM_WR_PORTS-1:0] wr_dropped_q, wr_dropped_d;
    logic                    rdy_en_q, rdy_en_d;

    logic [NUM_RD_PORTS*WIDTH-1:0] rd_data_d;
    logic [NUM_RD_PORTS-1:0]       rd_valid_d;

    for (genvar p = 0; p < NUM_PARTS; p++) begin : g_part
        ram_partition_ctrl #(
            .DEPTH      (DEPTH),
            .WIDTH      (WIDTH),
            .NUM_PARTS  (NUM_PARTS),
            .PART_IDX   (p),
            .RESET_VAL  (RESET_VAL),
            .SEQ_START  (SEQ_START),
            .GATE_DELAY (GATE_DELAY)
        ) u_ctrl (
            .clk         (clk),
            .reset       (reset),
            .gated_i     (partitionGated_i[p]),
            .on_o        (part_on[p]),
            .init_we_o   (init_we[p]),
            .init_row_o  (init_row[p]),
            .init_data_o (init_data[p])
        );
    end

    always_comb begin
        wr_commit = '0;
        for (int unsigned w = 0; w < NUM_WR_PORTS; w++) begin
            for (int unsigned p = 0; p < NUM_PARTS; p++) begin
                if (wrEn_i[w] && part_on[p] && (|addrWr_i[w*DEPTH + p*ROWS +: ROWS])) begin
                    wr_commit[w] = 1'b1;
                end
            end
        end
        wr_dropped_d = wrEn_i & ~wr_commit;
        rdy_en_d     = 1'b1;
    end

    // Init writes only touch non-ON partitions, so they never collide with user
    // writes; ascending port order lets the highest port win a shared row.
    always_comb begin
        mem_d = mem_q;
        for (int unsigned p = 0; p < NUM_PARTS; p++) begin
            if (init_we[p]) begin
                mem_d[init_row[p]] = init_data[p];
            end
        end
        for (int unsigned w = 0; w < NUM_WR_PORTS; w++) begin
            for (int unsigned r = 0; r < DEPTH; r++) begin
                if (wr_commit[w] && addrWr_i[w*DEPTH + r]) begin
                    mem_d[r] = dataWr_i[w*WIDTH +: WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q        <= '{default: '0};
            wr_dropped_q <= '0;
            rdy_en_q     <= 1'b0;
        end else begin
            mem_q        <= mem_d;
            wr_dropped_q <= wr_dropped_d;
            rdy_en_q     <= rdy_en_d;
        end
    end

    always_comb begin
        rd_data_d  = '0;
        rd_valid_d = '0;
        for (int unsigned rp = 0; rp < NUM_RD_PORTS; rp++) begin
            for (int unsigned p = 0; p < NUM_PARTS; p++) begin
                if (rdDataPartition_i[rp*NUM_PARTS_LOG +: NUM_PARTS_LOG] == NUM_PARTS_LOG'(p)
                    && part_on[p]) begin
                    rd_valid_d[rp] = 1'b1;
                    for (int unsigned i = 0; i < ROWS; i++) begin
                        if (addr_i[rp*DEPTH + p*ROWS + i]) begin
                            rd_data_d[rp*WIDTH +: WIDTH] |= mem_q[p*ROWS + i];
                        end
                    end
                end
            end
        end
    end

    if (READ_LATENCY == 0) begin : g_rd_comb
        assign data_o    = rd_data_d;
        assign rdValid_o = rd_valid_d;
    end else begin : g_rd_reg
        logic [NUM_RD_PORTS*WIDTH-1:0] rd_data_q;
        logic [NUM_RD_PORTS-1:0]       rd_valid_q;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                rd_data_q  <= '0;
                rd_valid_q <= '0;
            end else begin
                rd_data_q  <= rd_data_d;
                rd_valid_q <= rd_valid_d;
            end
        end

        assign data_o    = rd_data_q;
        assign rdValid_o = rd_valid_q;
    end

    // rdy_en_q keeps ramReady_o low while in reset even if every partition is gated.
    assign partReady_o = part_on;
    assign ramReady_o  = rdy_en_q & (&(part_on | partitionGated_i));
    assign wrDropped_o = wr_dropped_q;

    for (genvar rp = 0; rp < NUM_RD_PORTS; rp++) begin : g_rd_chk
        a_rd_onehot: assert property (@(posedge clk) disable iff (!reset)
            $onehot0(addr_i[rp*DEPTH +: DEPTH]));
    end
    for (genvar w = 0; w < NUM_WR_PORTS; w++) begin : g_wr_chk
        a_wr_onehot: assert property (@(posedge clk) disable iff (!reset)
            $onehot0(addrWr_i[w*DEPTH +: DEPTH]));
    end

endmodule
